barrel_unshift_seq: RTL and testbench

- Sequential inverse of the 8-bit rotate-right barrel shifter.
- Takes a word that was rotated right by `amt` and restores the original by rotating it left by the same `amt`, one bit position per clock.
- Sits on the receive side of a shift/unshift pair and uses valid/ready handshakes on both sides.
- Trades area for latency: one 1-bit rotator, no full crossbar.

---
 rtl/barrel_unshift_seq.sv | 87 ++++++++
 tb/tb_barrel_unshift_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/barrel_unshift_seq.sv
// Sequential rotate-left unshifter: restores a word that was rotated right by `amt`,
// moving one bit position per clock through a single 1-bit rotator.
module barrel_unshift_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [AMT_W:0] AmtLimit = (AMT_W + 1)'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] k_eff;

    // Out-of-range amounts pass through unchanged, matching the shifter's default case.
    assign k_eff = ({1'b0, amt} < AmtLimit) ? CNT_W'(amt) : '0;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        out_d   = out_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shreg_d = data;
                    cnt_d   = k_eff;
                    state_d = (k_eff == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Capture the result only on entry to DONE so out survives the next accept.
        if (state_d == StDone && state_q != StDone) begin
            out_d = shreg_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign out       = out_q;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign in_ready  = (state_q == StIdle) && !rst;

endmodule

// File: tb/tb_barrel_unshift_seq.sv
// Self-checking bench for barrel_unshift_seq: directed boundary cases plus a random
// rotate-right / unshift round trip against a plain-arithmetic reference.
module tb_barrel_unshift_seq;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic [3:0] amt;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    barrel_unshift_seq #(
        .WIDTH(8),
        .AMT_W(4),
        .CNT_W(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .amt      (amt),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int keff(input int a);
        return (a < 8) ? a : 0;
    endfunction

    function automatic logic [7:0] rotl(input int d, input int k);
        int r;
        r = (k == 0) ? d : (((d << k) | (d >> (8 - k))) & 255);
        return 8'(r);
    endfunction

    function automatic logic [7:0] rotr(input int d, input int k);
        int r;
        r = (k == 0) ? d : (((d >> k) | (d << (8 - k))) & 255);
        return 8'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Call between a falling edge and the next rising edge with the block idle.
    task automatic run_txn(input logic [7:0] d, input logic [3:0] a, input logic [7:0] exp,
                           input int rdy_pct);
        int k;
        int n;
        k        = keff(int'(a));
        data     = d;
        amt      = a;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 20) begin
            check("busy_shift", 32'(busy), 32'd1);
            in_valid  = 1'($urandom_range(0, 1));
            data      = 8'($urandom);
            amt       = 4'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("latency", 32'(n), 32'(k));
        check("out", 32'(out), 32'(exp));
        check("in_ready_done", 32'(in_ready), 32'd0);
        check("busy_done", 32'(busy), 32'd1);
        n = 0;
        do begin
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            @(negedge clk);
            n++;
            if (out_valid) begin
                check("hold_out", 32'(out), 32'(exp));
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
        end while (out_valid && n < 100);
        check("handoff_valid", 32'(out_valid), 32'd0);
        check("handoff_in_ready", 32'(in_ready), 32'd1);
        check("handoff_busy", 32'(busy), 32'd0);
        check("out_kept", 32'(out), 32'(exp));
        out_ready = 1'b0;
    endtask

    task automatic reset_mid_shift(input int pos);
        data     = 8'($urandom);
        amt      = 4'd6;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (pos) @(negedge clk);
        check("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_out", 32'(out), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_hold_ready", 32'(in_ready), 32'd0);
            check("mid_rst_hold_valid", 32'(out_valid), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        check("mid_rel_valid", 32'(out_valid), 32'd0);
        run_txn(8'hB1, 4'd3, 8'h8D, 100);
    endtask

    initial begin
        logic [7:0] orig;
        logic [3:0] a;

        rst       = 1'b1;
        data      = '0;
        amt       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Directed cases; expected words come from the rotate-left reference.
        run_txn(8'h8D, 4'd3, rotl(8'h8D, 3), 100);
        run_txn(8'h5A, 4'd0, 8'h5A, 100);
        run_txn(8'h01, 4'd7, 8'h80, 100);
        run_txn(8'h3C, 4'd9, 8'h3C, 100);
        run_txn(8'hB1, 4'd3, 8'h8D, 50);

        // Backpressure with a second word waiting on in_valid.
        data      = 8'hC0;
        amt       = 4'd2;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        data = 8'h11;
        amt  = 4'd1;
        repeat (2) @(negedge clk);
        repeat (5) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_out", 32'(out), 32'h03);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        check("bp_idle_out", 32'(out), 32'h03);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp2_shift_valid", 32'(out_valid), 32'd0);
        check("bp2_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("bp2_valid", 32'(out_valid), 32'd1);
        check("bp2_out", 32'(out), 32'h22);
        @(negedge clk);
        check("bp2_idle", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        reset_mid_shift(2);
        reset_mid_shift($urandom_range(1, 4));

        // Random round trip: original -> rotate right by amt -> DUT -> original.
        for (int i = 0; i < 1000; i++) begin
            orig = 8'($urandom);
            a    = 4'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn(rotr(int'(orig), keff(int'(a))), a, orig, 40);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
